// File: rtl/spatz_vrf_responder.sv
// spatz_vrf_responder: the responder side of the Spatz VRF access protocol.
// It holds the vector register file storage and serves one write port and
// NrReadPorts read ports. The storage is word-interleaved across NrBanks
// single-read banks. Each bank gives one read grant per cycle, chosen
// round-robin. A granted read returns registered data one cycle later.
// A write is accepted in the same cycle and acknowledged combinationally.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   vrf_waddr_i/wdata_i      write word address / data
//   vrf_we_i, vrf_wbe_i      write request, byte enables
//   vrf_wvalid_o             write committed this cycle (vrf_we_i gated by reset)
//   vrf_raddr_i, vrf_re_i    per-port read address / request
//   vrf_rdata_o              per-port read data (holds between responses)
//   vrf_rvalid_o             per-port response strobe, one cycle after grant
//
// Optional feature macro: SPATZ_VRF_WRITE_BYPASS_EN. When it is defined, a read
// granted in the same cycle as a write to the same address returns the newly
// written bytes. When it is undefined, that read returns the pre-write word.

// Per-bank round-robin arbiter. The grant goes to the first requester at or
// above the pointer, wrapping around. After a grant the pointer moves past
// the winner.
module spatz_vrf_bank_arb #(
   parameter int unsigned N  = 3,
   parameter int unsigned PW = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   logic [PW-1:0] ptr, win;
   logic          found;
   int unsigned   idx;

   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            win      = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     ptr <= '0;
      else if (found) ptr <= (32'(win) == N - 1) ? '0 : win + PW'(1);
   end
endmodule

module spatz_vrf_responder #(
   parameter int unsigned NrReadPorts = 3,
   parameter int unsigned NrBanks     = 2,
   parameter int unsigned AddrWidth   = 10,
   parameter int unsigned DataWidth   = 256
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [AddrWidth-1:0]                  vrf_waddr_i,
   input  logic [DataWidth-1:0]                  vrf_wdata_i,
   input  logic                                  vrf_we_i,
   input  logic [DataWidth/8-1:0]                vrf_wbe_i,
   output logic                                  vrf_wvalid_o,
   input  logic [NrReadPorts-1:0][AddrWidth-1:0] vrf_raddr_i,
   input  logic [NrReadPorts-1:0]                vrf_re_i,
   output logic [NrReadPorts-1:0][DataWidth-1:0] vrf_rdata_o,
   output logic [NrReadPorts-1:0]                vrf_rvalid_o
);
   localparam int unsigned NrBytes  = DataWidth / 8;
   localparam int unsigned Words    = 2 ** AddrWidth;
   localparam int unsigned PtrWidth = (NrReadPorts > 1) ? $clog2(NrReadPorts) : 1;

   // The storage is one flat array. Banking only affects read arbitration.
   // Because the banks are interleaved on the low address bits, a word's bank
   // is its address modulo NrBanks.
   logic [DataWidth-1:0] mem [Words];

   logic [NrBanks-1:0][NrReadPorts-1:0] breq, bgnt;
   logic [NrReadPorts-1:0]              gnt;
   logic [NrReadPorts-1:0][DataWidth-1:0] rword;

   function automatic int unsigned bank_of(input logic [AddrWidth-1:0] a);
      return 32'(a) % NrBanks;
   endfunction

   always_comb begin
      breq = '0;
      for (int unsigned b = 0; b < NrBanks; b++)
         for (int unsigned p = 0; p < NrReadPorts; p++)
            if (bank_of(vrf_raddr_i[p]) == b) breq[b][p] = vrf_re_i[p];
   end

   for (genvar b = 0; b < NrBanks; b++) begin : g_bank
      spatz_vrf_bank_arb #(.N(NrReadPorts), .PW(PtrWidth)) i_arb (
         .clk   (clk_i),
         .rst_n (rst_ni),
         .req   (breq[b]),
         .gnt   (bgnt[b])
      );
   end

   // Each port maps to exactly one bank, so at most one bank grants a given port.
   always_comb begin
      gnt = '0;
      for (int unsigned b = 0; b < NrBanks; b++) gnt |= bgnt[b];
   end

   always_comb begin
      rword = '0;
      for (int unsigned p = 0; p < NrReadPorts; p++) begin
         rword[p] = mem[vrf_raddr_i[p]];
`ifdef SPATZ_VRF_WRITE_BYPASS_EN
         // For a same-address write, the bytes being written this cycle are
         // taken from the write data. They are merged before the output register.
         if (vrf_we_i && vrf_waddr_i == vrf_raddr_i[p])
            for (int unsigned j = 0; j < NrBytes; j++)
               if (vrf_wbe_i[j]) rword[p][j*8 +: 8] = vrf_wdata_i[j*8 +: 8];
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned w = 0; w < Words; w++) mem[w] <= '0;
      end else if (vrf_we_i) begin
         for (int unsigned j = 0; j < NrBytes; j++)
            if (vrf_wbe_i[j]) mem[vrf_waddr_i][j*8 +: 8] <= vrf_wdata_i[j*8 +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vrf_rvalid_o <= '0;
         vrf_rdata_o  <= '0;
      end else begin
         vrf_rvalid_o <= gnt;
         for (int unsigned p = 0; p < NrReadPorts; p++)
            if (gnt[p]) vrf_rdata_o[p] <= rword[p];
      end
   end

   assign vrf_wvalid_o = vrf_we_i & rst_ni;
endmodule

// File: tb/tb_spatz_vrf_responder.sv
// Testbench for spatz_vrf_responder (3 read ports, 2 banks, 64-word x 64-bit).
// A reference model, updated at every posedge, keeps the expected storage,
// the round-robin pointers and the expected outputs. A compare process checks
// every port at each negedge. The directed steps also pin literal values.
module tb_spatz_vrf_responder;
   localparam int NR = 3, NB = 2, AW = 6, DW = 64, NBY = DW / 8;

   logic                   clk = 1'b0, rst_n = 1'b0;
   logic [AW-1:0]          waddr = '0;
   logic [DW-1:0]          wdata = '0;
   logic                   we = 1'b0;
   logic [NBY-1:0]         wbe = '0;
   logic                   wvalid;
   logic [NR-1:0][AW-1:0]  raddr = '0;
   logic [NR-1:0]          re = '0;
   logic [NR-1:0][DW-1:0]  rdata;
   logic [NR-1:0]          rvalid;

   int total = 0, bad = 0;

   spatz_vrf_responder #(.NrReadPorts(NR), .NrBanks(NB), .AddrWidth(AW), .DataWidth(DW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .vrf_waddr_i(waddr), .vrf_wdata_i(wdata), .vrf_we_i(we), .vrf_wbe_i(wbe),
      .vrf_wvalid_o(wvalid),
      .vrf_raddr_i(raddr), .vrf_re_i(re), .vrf_rdata_o(rdata), .vrf_rvalid_o(rvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0]         mmem [2**AW];
   int                    rr [NB];
   logic [NR-1:0]         exp_rv = '0;
   logic [NR-1:0][DW-1:0] exp_rd = '0;

   always @(posedge clk) begin
      logic [NR-1:0] won;
      logic [DW-1:0] w;
      if (!rst_n) begin
         for (int i = 0; i < 2**AW; i++) mmem[i] = '0;
         for (int b = 0; b < NB; b++) rr[b] = 0;
         exp_rv = '0;
         exp_rd = '0;
      end else begin
         won = '0;
         for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < NR; k++) begin
               int p;
               p = (rr[b] + k) % NR;
               if (re[p] && (int'(raddr[p]) % NB) == b) begin
                  won[p] = 1'b1;
                  rr[b] = (p + 1) % NR;
                  break;
               end
            end
         end
         for (int p = 0; p < NR; p++) if (won[p]) begin
            w = mmem[raddr[p]];
`ifdef SPATZ_VRF_WRITE_BYPASS_EN
            if (we && waddr == raddr[p])
               for (int j = 0; j < NBY; j++) if (wbe[j]) w[j*8 +: 8] = wdata[j*8 +: 8];
`endif
            exp_rd[p] = w;
         end
         exp_rv = won;
         if (we) for (int j = 0; j < NBY; j++) if (wbe[j]) mmem[waddr][j*8 +: 8] = wdata[j*8 +: 8];
      end
   end

   always @(negedge clk) begin
      for (int p = 0; p < NR; p++) begin
         chk($sformatf("model_rvalid%0d", p), DW'(rvalid[p]), DW'(exp_rv[p]));
         chk($sformatf("model_rdata%0d", p), rdata[p], exp_rd[p]);
      end
      chk("model_wvalid", DW'(wvalid), DW'(we & rst_n));
   end

   // ---------------- directed stimulus ----------------
   initial begin
      repeat (2) @(negedge clk);
      chk("reset_rvalid", DW'(rvalid), '0);
      chk("reset_rdata0", rdata[0], '0);
      #1 rst_n = 1'b1;

      // Write 0xA5 to every byte of address 4. The acknowledge is expected in the same cycle.
      we = 1'b1; waddr = 6'd4; wdata = {NBY{8'hA5}}; wbe = '1;
      @(negedge clk);
      chk("write_ack", DW'(wvalid), DW'(1));
      #1 we = 1'b0; re = 3'b001; raddr[0] = 6'd4;
      @(negedge clk);
      chk("rd_a5_valid", DW'(rvalid), DW'(3'b001));
      chk("rd_a5_data", rdata[0], {NBY{8'hA5}});

      // A single read from port 2 to bank 0 moves that bank's pointer back to 0.
      #1 re = 3'b100; raddr[2] = 6'd0;
      @(negedge clk);
      // Three ports contend for bank 0. Each port is released after it is served.
      #1 re = 3'b111; raddr[0] = 6'd0; raddr[1] = 6'd2; raddr[2] = 6'd4;
      @(negedge clk);
      chk("rr_first", DW'(rvalid), DW'(3'b001));
      #1 re[0] = 1'b0;
      @(negedge clk);
      chk("rr_second", DW'(rvalid), DW'(3'b010));
      #1 re[1] = 1'b0;
      @(negedge clk);
      chk("rr_third", DW'(rvalid), DW'(3'b100));
      chk("rr_third_data", rdata[2], {NBY{8'hA5}});
      #1 re = '0;

      // Reads to different banks in the same cycle are both served.
      raddr[0] = 6'd1; raddr[1] = 6'd2; re = 3'b011;
      @(negedge clk);
      chk("two_banks", DW'(rvalid), DW'(3'b011));
      #1 re = '0;

      // A write with no byte enables is acknowledged but changes nothing.
      we = 1'b1; waddr = 6'd4; wbe = '0; wdata = '0;
      @(negedge clk);
      chk("wbe0_ack", DW'(wvalid), DW'(1));
      #1 we = 1'b0; re = 3'b001; raddr[0] = 6'd4;
      @(negedge clk);
      chk("wbe0_keep", rdata[0], {NBY{8'hA5}});

      // A write and a read to the same address in the same cycle.
      #1 we = 1'b1; waddr = 6'd6; wbe = 8'h01; wdata = '1; re = 3'b001; raddr[0] = 6'd6;
      @(negedge clk);
`ifdef SPATZ_VRF_WRITE_BYPASS_EN
      chk("same_addr_rd", rdata[0], 64'h0000_0000_0000_00FF);
`else
      chk("same_addr_rd", rdata[0], 64'h0);
`endif
      #1 we = 1'b0;
      @(negedge clk);
      chk("after_write_rd", rdata[0], 64'h0000_0000_0000_00FF);

      // A read is granted, then reset arrives in the following cycle.
      #1 raddr[0] = 6'd4; re = 3'b001;
      @(negedge clk);
      #1 rst_n = 1'b0; we = 1'b1; wbe = '0;
      @(negedge clk);
      chk("rst_rvalid", DW'(rvalid), '0);
      chk("rst_rdata", rdata[0], '0);
      chk("rst_wvalid", DW'(wvalid), '0);
      #1 rst_n = 1'b1; we = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", DW'(rvalid), DW'(3'b001));
      chk("post_rst_data", rdata[0], '0);

      // Mixed traffic, checked only by the model.
      for (int c = 0; c < 40; c++) begin
         #1;
         re = NR'($urandom_range(0, 7));
         for (int p = 0; p < NR; p++) raddr[p] = AW'($urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         waddr = AW'($urandom_range(0, 7));
         wbe = NBY'($urandom);
         wdata = {$urandom, $urandom};
         @(negedge clk);
      end
      #1 re = '0; we = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
